// File: rtl/scarv_cop_insn_ctrl_pkg.sv
// Shared types and constants for the co-processor instruction sequencer:
// FSM state encodings and the instruction result codes.
package scarv_cop_insn_ctrl_pkg;

    typedef enum logic [1:0] {
        SCARV_COP_CTL_IDLE = 2'd0,
        SCARV_COP_CTL_EXEC = 2'd1,
        SCARV_COP_CTL_RSP  = 2'd2
    } ctl_state_t;

    localparam logic [2:0] SCARV_COP_INSN_SUCCESS = 3'b000;
    localparam logic [2:0] SCARV_COP_INSN_BAD_INS = 3'b001;
    localparam logic [2:0] SCARV_COP_INSN_BAD_LAD = 3'b010;
    localparam logic [2:0] SCARV_COP_INSN_LD_ERR  = 3'b011;
    localparam logic [2:0] SCARV_COP_INSN_TIMEOUT = 3'b111;

endpackage

// File: rtl/scarv_cop_insn_ctrl.sv
// CPU-side instruction sequencer: accepts one instruction, holds it for the
// functional units, then returns the result over the response handshake.
module scarv_cop_insn_ctrl
    import scarv_cop_insn_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CW      = 7
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        cpu_insn_req,
    output logic        cop_insn_ack,
    input  logic        cpu_abort_req,
    input  logic [31:0] cpu_insn_enc,
    input  logic [31:0] cpu_rs1,
    output logic        cop_insn_rsp,
    input  logic        cpu_insn_ack,
    output logic [2:0]  cop_result,
    output logic        cop_wen,
    output logic [4:0]  cop_waddr,
    output logic [31:0] cop_wdata,
    output logic [31:0] ctl_insn_enc,
    output logic [31:0] ctl_rs1,
    output logic        fu_ivalid,
    output logic        fu_abort,
    input  logic        fu_idone,
    input  logic [2:0]  fu_result,
    input  logic        fu_gpr_wen,
    input  logic [4:0]  fu_gpr_waddr,
    input  logic [31:0] fu_gpr_wdata,
    output logic        ctl_busy
);

    ctl_state_t      state_reg;
    ctl_state_t      state_next;
    logic [CW-1:0]   wdog_reg;
    logic            timeout_hit;
    logic            accept;

    // TIMEOUT == 0 disables the watchdog entirely.
    assign timeout_hit  = (TIMEOUT != 0) && (wdog_reg == CW'(TIMEOUT - 1));

    assign cop_insn_ack = (state_reg == SCARV_COP_CTL_IDLE) && !cpu_abort_req;
    assign fu_ivalid    = (state_reg == SCARV_COP_CTL_EXEC);
    assign cop_insn_rsp = (state_reg == SCARV_COP_CTL_RSP);
    assign ctl_busy     = (state_reg != SCARV_COP_CTL_IDLE);
    assign accept       = cpu_insn_req && cop_insn_ack;

    // Abort outranks a same-cycle done; done outranks a same-cycle timeout.
    always_comb begin
        state_next = state_reg;
        fu_abort   = 1'b0;
        unique case (state_reg)
            SCARV_COP_CTL_IDLE: begin
                if (accept) state_next = SCARV_COP_CTL_EXEC;
            end
            SCARV_COP_CTL_EXEC: begin
                if (cpu_abort_req) begin
                    state_next = SCARV_COP_CTL_IDLE;
                    fu_abort   = 1'b1;
                end else if (fu_idone) begin
                    state_next = SCARV_COP_CTL_RSP;
                end else if (timeout_hit) begin
                    state_next = SCARV_COP_CTL_RSP;
                    fu_abort   = 1'b1;
                end
            end
            SCARV_COP_CTL_RSP: begin
                if (cpu_insn_ack) state_next = SCARV_COP_CTL_IDLE;
            end
            default: state_next = SCARV_COP_CTL_IDLE;
        endcase
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_reg    <= SCARV_COP_CTL_IDLE;
            ctl_insn_enc <= '0;
            ctl_rs1      <= '0;
            cop_result   <= '0;
            cop_wen      <= 1'b0;
            cop_waddr    <= '0;
            cop_wdata    <= '0;
            wdog_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == SCARV_COP_CTL_IDLE && accept) begin
                ctl_insn_enc <= cpu_insn_enc;
                ctl_rs1      <= cpu_rs1;
                wdog_reg     <= '0;
            end
            if (state_reg == SCARV_COP_CTL_EXEC) begin
                if (wdog_reg != '1) wdog_reg <= wdog_reg + 1'b1;
                if (!cpu_abort_req) begin
                    if (fu_idone) begin
                        cop_result <= fu_result;
                        cop_wen    <= fu_gpr_wen;
                        cop_waddr  <= fu_gpr_waddr;
                        cop_wdata  <= fu_gpr_wdata;
                    end else if (timeout_hit) begin
                        cop_result <= SCARV_COP_INSN_TIMEOUT;
                        cop_wen    <= 1'b0;
                    end
                end
            end
            // Drop the write enable on exit so a stale wen never leaks into IDLE.
            if (state_reg == SCARV_COP_CTL_RSP && cpu_insn_ack) cop_wen <= 1'b0;
        end
    end

endmodule
